// File: rtl/stopwatch_bcd_core.sv
// MM:SS BCD stopwatch driven by a synchronised slow tick, with start/stop/clear control.
// Optional build macro STOPWATCH_COUNTDOWN_EN adds dir_i to select counting down.
module stopwatch_bcd_core #(
  parameter int TICKS_PER_SEC = 2,
  parameter int MAX_MIN_TENS  = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic       dir_i,
`endif
  output logic [3:0] sec_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] min_tens_o,
  output logic       running_o,
  output logic       wrap_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [7:0] PRE_LAST      = 8'(TICKS_PER_SEC - 1);
  localparam logic [3:0] MIN_TENS_LAST = 4'(MAX_MIN_TENS);

  state_e     state_q, state_d;
  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic       rise;
  logic [7:0] pre_q, pre_d;
  logic       step;
  logic       count_down;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;
  logic       at_max;
  logic       at_zero;

  always_comb begin
    s1_d = tick_i;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
  end

  // Next state: clear beats stop beats start; clear+stop while running drops to IDLE.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      if ((state_q == RUN) && !stop_i) begin
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end else if (stop_i) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (start_i) begin
      if (state_q != RUN) begin
        state_d = RUN;
      end
    end
  end

  always_comb begin
    running_d = (state_d == RUN);
  end

  // Prescaler keeps its phase through PAUSE; a rise coinciding with clear is dropped.
  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (clear_i) begin
      pre_d = 8'd0;
    end else if ((state_q == RUN) && rise) begin
      if (pre_q == PRE_LAST) begin
        pre_d = 8'd0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 8'd1;
      end
    end
  end

`ifdef STOPWATCH_COUNTDOWN_EN
  always_comb begin
    count_down = dir_i;
  end
`else
  always_comb begin
    count_down = 1'b0;
  end
`endif

  always_comb begin
    at_max  = (min_tens_q == MIN_TENS_LAST) && (min_ones_q == 4'd9) &&
              (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
    at_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
              (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
  end

  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    if (clear_i) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (step && !count_down) begin
      if (at_max) begin
        sec_ones_d = 4'd0;
        sec_tens_d = 4'd0;
        min_ones_d = 4'd0;
        min_tens_d = 4'd0;
        wrap_d     = 1'b1;
      end else if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q != 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = 4'd0;
          if (min_ones_q != 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = 4'd0;
            min_tens_d = min_tens_q + 4'd1;
          end
        end
      end
    end else if (step && count_down) begin
      if (at_zero) begin
        sec_ones_d = 4'd9;
        sec_tens_d = 4'd5;
        min_ones_d = 4'd9;
        min_tens_d = MIN_TENS_LAST;
        wrap_d     = 1'b1;
      end else if (sec_ones_q != 4'd0) begin
        sec_ones_d = sec_ones_q - 4'd1;
      end else begin
        sec_ones_d = 4'd9;
        if (sec_tens_q != 4'd0) begin
          sec_tens_d = sec_tens_q - 4'd1;
        end else begin
          sec_tens_d = 4'd5;
          if (min_ones_q != 4'd0) begin
            min_ones_d = min_ones_q - 4'd1;
          end else begin
            min_ones_d = 4'd9;
            min_tens_d = min_tens_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      pre_q      <= 8'd0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      pre_q      <= pre_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sec_ones_o = sec_ones_q;
  assign sec_tens_o = sec_tens_q;
  assign min_ones_o = min_ones_q;
  assign min_tens_o = min_tens_q;
  assign running_o  = running_q;
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Self-checking bench for stopwatch_bcd_core: directed scenarios plus random traffic,
// all compared every cycle against an elapsed-seconds reference model.
module tb_stopwatch_bcd_core;

  localparam int TPS    = 2;
  localparam int MMT    = 5;
  localparam int PERIOD = (MMT * 10 + 10) * 60;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       tick_i;
  logic       start_i;
  logic       stop_i;
  logic       clear_i;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic       dir_i;
`endif
  logic [3:0] sec_ones_o;
  logic [3:0] sec_tens_o;
  logic [3:0] min_ones_o;
  logic [3:0] min_tens_o;
  logic       running_o;
  logic       wrap_o;

  int checkCount = 0;
  int failCount  = 0;
  int wrapSeen   = 0;

  int mTotal;
  int mPre;
  int mState;
  bit mWrap;
  bit samp1, samp2, samp3;

  stopwatch_bcd_core #(
    .TICKS_PER_SEC(TPS),
    .MAX_MIN_TENS (MMT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tick_i    (tick_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .clear_i   (clear_i),
`ifdef STOPWATCH_COUNTDOWN_EN
    .dir_i     (dir_i),
`endif
    .sec_ones_o(sec_ones_o),
    .sec_tens_o(sec_tens_o),
    .min_ones_o(min_ones_o),
    .min_tens_o(min_tens_o),
    .running_o (running_o),
    .wrap_o    (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] toBcd(input int t);
    int s;
    int m;
    s = t % 60;
    m = t / 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dutDigits();
    return {min_tens_o, min_ones_o, sec_tens_o, sec_ones_o};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: elapsed seconds with a tick-to-step delay of two clock edges.
  task automatic modelStep(input bit rst, input bit start, input bit stop,
                           input bit clear, input bit tick);
    bit rise;
    if (rst) begin
      mTotal = 0;
      mPre   = 0;
      mState = ST_IDLE;
      mWrap  = 1'b0;
      samp1  = 1'b0;
      samp2  = 1'b0;
      samp3  = 1'b0;
    end else begin
      rise  = samp2 && !samp3;
      mWrap = 1'b0;
      if (clear) begin
        mTotal = 0;
        mPre   = 0;
        mState = (mState == ST_RUN && !stop) ? ST_RUN : ST_IDLE;
      end else begin
        if (mState == ST_RUN && rise) begin
          mPre++;
          if (mPre == TPS) begin
            mPre = 0;
            mTotal++;
            if (mTotal == PERIOD) begin
              mTotal = 0;
              mWrap  = 1'b1;
            end
          end
        end
        if (stop) begin
          if (mState == ST_RUN) mState = ST_PAUSE;
        end else if (start) begin
          mState = ST_RUN;
        end
      end
      samp3 = samp2;
      samp2 = samp1;
      samp1 = tick;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit start, input bit stop,
                               input bit clear, input bit tick);
    rst_i   = rst;
    start_i = start;
    stop_i  = stop;
    clear_i = clear;
    tick_i  = tick;
    @(posedge clk_i);
    modelStep(rst, start, stop, clear, tick);
    @(negedge clk_i);
    wrapSeen += int'(wrap_o);
    checkOutput("digits", 32'(dutDigits()), 32'(toBcd(mTotal)));
    checkOutput("running", 32'(running_o), 32'(mState == ST_RUN));
    checkOutput("wrap", 32'(wrap_o), 32'(mWrap));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic pulse(input bit start, input bit stop, input bit clear);
    applyStimulus(0, start, stop, clear, 0);
  endtask

  task automatic tickEdges(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
  endtask

  task automatic tickUntil(input int target);
    int guard;
    guard = 0;
    while (mTotal != target && guard < 20000) begin
      tickEdges(1);
      guard++;
    end
    checkOutput("reach_target", 32'(mTotal), 32'(target));
  endtask

  initial begin
    bit tickLevel;
    rst_i   = 1'b1;
    tick_i  = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    clear_i = 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
    dir_i   = 1'b0;
`endif
    modelStep(1, 0, 0, 0, 0);
    @(negedge clk_i);

    // Reset state
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_digits", 32'(dutDigits()), 32'h0);
    checkOutput("reset_running", 32'(running_o), 32'h0);
    checkOutput("reset_wrap", 32'(wrap_o), 32'h0);
    idleCycles(3);

    // Start, four rises -> 00:02, with exact latency on the last second
    pulse(1, 0, 0);
    checkOutput("start_running", 32'(running_o), 32'h1);
    tickEdges(3);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lat_before", 32'(dutDigits()), 32'h0001);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lat_after", 32'(dutDigits()), 32'h0002);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("four_ticks_digits", 32'(dutDigits()), 32'h0002);
    checkOutput("four_ticks_running", 32'(running_o), 32'h1);

    // 09:59 -> 10:00 without wrap, then 59:59 -> 00:00 with one wrap pulse
    tickUntil(599);
    wrapSeen = 0;
    tickEdges(2);
    checkOutput("ten_min_digits", 32'(dutDigits()), 32'h1000);
    checkOutput("ten_min_nowrap", 32'(wrapSeen), 32'h0);
    tickUntil(PERIOD - 1);
    checkOutput("max_digits", 32'(dutDigits()), 32'h5959);
    wrapSeen = 0;
    tickEdges(2);
    checkOutput("wrap_digits", 32'(dutDigits()), 32'h0000);
    checkOutput("wrap_pulse_count", 32'(wrapSeen), 32'h1);
    tickEdges(2);
    checkOutput("after_wrap_digits", 32'(dutDigits()), 32'h0001);

    // Pause keeps sub-second phase
    pulse(0, 0, 1);
    checkOutput("clear_run_running", 32'(running_o), 32'h1);
    tickEdges(11);
    checkOutput("pre_phase_digits", 32'(dutDigits()), 32'h0005);
    pulse(0, 1, 0);
    tickEdges(3);
    checkOutput("paused_digits", 32'(dutDigits()), 32'h0005);
    checkOutput("paused_running", 32'(running_o), 32'h0);
    pulse(1, 0, 0);
    tickEdges(1);
    checkOutput("resume_digits", 32'(dutDigits()), 32'h0006);

    // start+stop together, then clear+stop together
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("startstop_running", 32'(running_o), 32'h0);
    pulse(1, 0, 0);
    checkOutput("restart_running", 32'(running_o), 32'h1);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("clearstop_digits", 32'(dutDigits()), 32'h0);
    checkOutput("clearstop_running", 32'(running_o), 32'h0);
    tickEdges(2);
    checkOutput("idle_no_count", 32'(dutDigits()), 32'h0);

    // Clear coinciding with a rise at pre=1 discards that rise
    pulse(1, 0, 0);
    tickEdges(1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("clear_rise_digits", 32'(dutDigits()), 32'h0);
    checkOutput("clear_rise_running", 32'(running_o), 32'h1);
    tickEdges(2);
    checkOutput("clear_rise_after", 32'(dutDigits()), 32'h0001);

    // Reset mid-count at 03:27
    tickUntil(207);
    checkOutput("pre_reset_digits", 32'(dutDigits()), 32'h0327);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("midreset_digits", 32'(dutDigits()), 32'h0);
    checkOutput("midreset_running", 32'(running_o), 32'h0);
    tickEdges(3);
    checkOutput("midreset_hold", 32'(dutDigits()), 32'h0);
    pulse(1, 0, 0);
    tickEdges(2);
    checkOutput("midreset_restart", 32'(dutDigits()), 32'h0001);

    // Random traffic
    tickLevel = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) tickLevel = ~tickLevel;
      applyStimulus($urandom_range(0, 499) == 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 39) == 0,
                    tickLevel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
